wb_dbg_master: RTL and testbench

UART-driven Wishbone bus master for host-side debug access to the SoC address space. It parses a compact byte protocol from a UART receive byte stream and executes single 32-bit Wishbone read or write cycles. It returns a status byte and, for reads, data bytes over the UART transmit byte stream. It occupies a spare master port on the Wishbone interconnect and arbitrates with the LM32 instruction and data masters.

---
 rtl/wb_dbg_pkg.sv | 24 ++
 rtl/wb_dbg_txser.sv | 45 ++++
 rtl/wb_dbg_master.sv | 149 ++++++++++++++
 tb/tb_wb_dbg_master.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dbg_pkg.sv
// Shared constants and FSM state type for the UART-driven Wishbone debug master.
package wb_dbg_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  localparam logic [7:0] ST_ACK   = 8'h00;
  localparam logic [7:0] ST_ERR   = 8'hEE;
  localparam logic [7:0] ST_TMO   = 8'hEF;
  localparam logic [7:0] ST_BADOP = 8'hFF;
  localparam logic [7:0] PING_RSP = 8'h55;

  localparam int RETRIES_MAX = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/wb_dbg_txser.sv
// Response serializer: loads up to 5 bytes (first byte in [39:32]) and paces
// them out as tx_stb pulses, never in back-to-back cycles and only when not busy.
module wb_dbg_txser (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [39:0] i_bytes,
  input  logic [2:0]  i_count,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_stb,
  output logic        o_busy
);

  logic [39:0] r_sr;
  logic [2:0]  r_cnt;
  logic [7:0]  r_data;
  logic        r_stb;

  // r_stb doubles as the hold-off: the transmitter's busy flag may lag one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_stb  <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (i_load) begin
        r_sr  <= i_bytes;
        r_cnt <= i_count;
      end else if (r_cnt != 3'd0 && !r_stb && !i_tx_busy) begin
        r_data <= r_sr[39:32];
        r_sr   <= {r_sr[31:0], 8'h00};
        r_cnt  <= r_cnt - 3'd1;
        r_stb  <= 1'b1;
      end
    end
  end

  assign o_tx_data = r_data;
  assign o_tx_stb  = r_stb;
  assign o_busy    = (r_cnt != 3'd0);

endmodule

// File: rtl/wb_dbg_master.sv
// UART byte-protocol to single 32-bit Wishbone read/write master.
// Define WB_DBG_RETRY_EN to reissue cycles terminated by rty (up to 3 times).
module wb_dbg_master
  import wb_dbg_pkg::*;
#(
  parameter int timeout_cycles = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_stb,
  output logic [7:0]  tx_data,
  output logic        tx_stb,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic [2:0]  dbg_state
);

  localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

  state_t      r_state, w_next;
  logic [31:0] r_adr, r_dat;
  logic        r_we;
  logic [1:0]  r_bcnt;
  logic [15:0] r_tmo;
  logic        w_cyc, w_retry, w_term, w_tmo_hit;
  logic        w_frame_byte, w_last_byte, w_opc_known;
  logic        w_load, w_ser_busy;
  logic [39:0] w_load_bytes;
  logic [2:0]  w_load_cnt;
  logic [7:0]  w_status;

  // Handshakes: rx_stb/tx_stb are single-cycle valid pulses with no back-pressure
  // on rx; tx_busy acts as not-ready; a bus cycle ends on the first sampled terminator.

`ifdef WB_DBG_RETRY_EN
  logic [1:0] r_rty;
  logic       r_gap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rty <= '0;
      r_gap <= 1'b0;
    end else begin
      r_gap <= w_retry;
      if (r_state != S_BUS) r_rty <= '0;
      else if (w_retry)     r_rty <= r_rty + 2'd1;
    end
  end

  assign w_cyc   = (r_state == S_BUS) && !r_gap;
  assign w_retry = w_cyc && !wb_ack_i && !wb_err_i && wb_rty_i
                   && (r_rty != 2'(RETRIES_MAX));
`else
  assign w_cyc   = (r_state == S_BUS);
  assign w_retry = 1'b0;
`endif

  assign w_tmo_hit    = w_cyc && (r_tmo == TMO_LAST);
  assign w_term       = w_cyc && !w_retry && (wb_ack_i || wb_err_i || wb_rty_i || w_tmo_hit);
  assign w_frame_byte = rx_stb && (r_state == S_ADDR || r_state == S_WDATA);
  assign w_last_byte  = w_frame_byte && (r_bcnt == 2'd3);
  assign w_opc_known  = (rx_data == OP_READ) || (rx_data == OP_WRITE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (rx_stb)      w_next = w_opc_known ? S_ADDR : S_RESP;
      S_ADDR:  if (w_last_byte) w_next = r_we ? S_WDATA : S_BUS;
      S_WDATA: if (w_last_byte) w_next = S_BUS;
      S_BUS:   if (w_term)      w_next = S_RESP;
      S_RESP:  if (!w_ser_busy) w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load       = 1'b0;
    w_load_bytes = '0;
    w_load_cnt   = '0;
    if (wb_ack_i)                    w_status = ST_ACK;
    else if (wb_err_i || wb_rty_i)   w_status = ST_ERR;
    else                             w_status = ST_TMO;
    if (r_state == S_IDLE && rx_stb && !w_opc_known) begin
      w_load       = 1'b1;
      w_load_cnt   = 3'd1;
      w_load_bytes = {(rx_data == OP_PING) ? PING_RSP : ST_BADOP, 32'h0};
    end else if (w_term) begin
      w_load       = 1'b1;
      w_load_cnt   = r_we ? 3'd1 : 3'd5;
      w_load_bytes = {w_status, wb_ack_i ? wb_dat_i : 32'h0};
    end
    wb_cyc_o  = w_cyc;
    wb_stb_o  = w_cyc;
    wb_we_o   = w_cyc && r_we;
    wb_sel_o  = w_cyc ? 4'hF : 4'h0;
    wb_adr_o  = r_adr & 32'hFFFF_FFFC;
    wb_dat_o  = r_dat;
    dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_adr  <= '0;
      r_dat  <= '0;
      r_we   <= 1'b0;
      r_bcnt <= '0;
    end else begin
      if (r_state == S_IDLE && rx_stb) r_we <= (rx_data == OP_WRITE);
      if (w_frame_byte) r_bcnt <= r_bcnt + 2'd1;
      if (w_frame_byte && r_state == S_ADDR)  r_adr <= {r_adr[23:0], rx_data};
      if (w_frame_byte && r_state == S_WDATA) r_dat <= {r_dat[23:0], rx_data};
    end
  end

  // Counts cycles of the current strobe; cleared between attempts.
  always_ff @(posedge clk) begin
    if (rst)                              r_tmo <= '0;
    else if (!w_cyc || w_retry || w_term) r_tmo <= '0;
    else                                  r_tmo <= r_tmo + 16'd1;
  end

  wb_dbg_txser u_txser (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_bytes   (w_load_bytes),
    .i_count   (w_load_cnt),
    .i_tx_busy (tx_busy),
    .o_tx_data (tx_data),
    .o_tx_stb  (tx_stb),
    .o_busy    (w_ser_busy)
  );

endmodule

// File: tb/tb_wb_dbg_master.sv
// Bench for wb_dbg_master: host byte driver, paced UART TX sink, Wishbone slave
// with selectable behaviour, and a command-level reference model.
module tb_wb_dbg_master;
  import wb_dbg_pkg::*;

  localparam int TMO = 16;
`ifdef WB_DBG_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int M_BRAM = 0, M_ERR = 1, M_SILENT = 2, M_RTY = 3, M_ALL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_stb = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_stb;
  logic        tx_busy = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic [2:0]  dbg_state;

  wb_dbg_master #(.timeout_cycles(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(rx_stb),
    .tx_data(tx_data), .tx_stb(tx_stb), .tx_busy(tx_busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, required completion before 500us");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bram    [logic [31:0]];
  int slv_mode = M_BRAM, slv_max_wait = 0, slv_rty_n = 0, slv_rty_left = 0;
  int pulses = 0, cyc_cycles = 0, exp_pulses = 0;
  logic [31:0] last_adr = '0, last_dat = '0;
  logic        last_we = 1'b0;
  logic [3:0]  last_sel = '0;

  // ---------------- UART TX sink with random busy ----------------
  int   busy_cnt = 0;
  logic prev_tx_stb = 1'b0;
  always @(negedge clk) begin
    if (tx_stb) begin
      got_q.push_back(tx_data);
      n_vec++;
      if (prev_tx_stb || tx_busy) begin
        n_err++;
        $display("FAIL tx_pacing prev_stb=%b busy=%b at pulse, required both 0", prev_tx_stb, tx_busy);
      end
      busy_cnt = $urandom_range(0, 4);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);
    prev_tx_stb = tx_stb;
  end

  // ---------------- Wishbone slave ----------------
  int   wait_cnt = 0, wait_tgt = 0;
  logic prev_stb = 1'b0;
  always @(negedge clk) begin
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    wb_dat_i = $urandom;
    if (wb_cyc_o && wb_stb_o) begin
      if (!prev_stb) begin
        pulses++;
        wait_cnt = 0;
        wait_tgt = $urandom_range(0, slv_max_wait);
      end
      cyc_cycles++;
      if (slv_mode != M_SILENT) begin
        if (wait_cnt < wait_tgt) begin
          wait_cnt++;
        end else begin
          last_adr = wb_adr_o; last_dat = wb_dat_o; last_we = wb_we_o; last_sel = wb_sel_o;
          if (slv_mode == M_ERR) begin
            wb_err_i = 1'b1; wb_rty_i = 1'b1;
          end else if (slv_mode == M_RTY && slv_rty_left > 0) begin
            wb_rty_i = 1'b1; slv_rty_left--;
          end else begin
            wb_ack_i = 1'b1;
            if (slv_mode == M_ALL) begin wb_err_i = 1'b1; wb_rty_i = 1'b1; end
            if (wb_we_o) bram[wb_adr_o] = wb_dat_o;
            else wb_dat_i = bram.exists(wb_adr_o) ? bram[wb_adr_o] : 32'h0;
          end
        end
      end
    end
    prev_stb = wb_cyc_o && wb_stb_o;
  end

  // ---------------- reference model: command -> expected reply bytes ----------------
  task automatic model_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] wa, rd;
    logic [7:0]  st;
    logic        acked;
    wa = addr & 32'hFFFF_FFFC;
    exp_q.delete();
    exp_pulses = 0;
    if (op == OP_PING) begin exp_q.push_back(8'h55); return; end
    if (op != OP_READ && op != OP_WRITE) begin exp_q.push_back(8'hFF); return; end
    st = 8'h00; acked = 1'b1; exp_pulses = 1;
    if (slv_mode == M_ERR) begin st = 8'hEE; acked = 1'b0; end
    else if (slv_mode == M_SILENT) begin st = 8'hEF; acked = 1'b0; end
    else if (slv_mode == M_RTY) begin
      if (RETRY_EN && slv_rty_n <= 3) exp_pulses = slv_rty_n + 1;
      else begin
        st = 8'hEE; acked = 1'b0;
        exp_pulses = RETRY_EN ? 4 : 1;
      end
    end
    exp_q.push_back(st);
    if (op == OP_WRITE && acked) ref_mem[wa] = data;
    if (op == OP_READ) begin
      rd = (acked && ref_mem.exists(wa)) ? ref_mem[wa] : 32'h0;
      for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_stb = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0; rx_data = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    model_cmd(op, addr, data);
    got_q.delete();
    pulses = 0; cyc_cycles = 0; slv_rty_left = slv_rty_n;
    send_byte(op);
    if (op == OP_READ || op == OP_WRITE)
      for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    if (op == OP_WRITE)
      for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
    for (int c = 0; c < 400 && got_q.size() < exp_q.size(); c++) @(negedge clk);
    repeat (12) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec += 9;
    if (tx_data !== 8'h00)   begin n_err++; $display("FAIL rst_tx_data got %h required 00", tx_data); end
    if (tx_stb !== 1'b0)     begin n_err++; $display("FAIL rst_tx_stb got %b required 0", tx_stb); end
    if (wb_cyc_o !== 1'b0)   begin n_err++; $display("FAIL rst_cyc got %b required 0", wb_cyc_o); end
    if (wb_stb_o !== 1'b0)   begin n_err++; $display("FAIL rst_stb got %b required 0", wb_stb_o); end
    if (wb_we_o !== 1'b0)    begin n_err++; $display("FAIL rst_we got %b required 0", wb_we_o); end
    if (wb_sel_o !== 4'h0)   begin n_err++; $display("FAIL rst_sel got %h required 0", wb_sel_o); end
    if (wb_adr_o !== 32'h0)  begin n_err++; $display("FAIL rst_adr got %h required 0", wb_adr_o); end
    if (wb_dat_o !== 32'h0)  begin n_err++; $display("FAIL rst_dat got %h required 0", wb_dat_o); end
    if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL rst_state got %0d required IDLE", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ping();
    slv_mode = M_BRAM;
    do_cmd(OP_PING, 32'h0, 32'h0);
    n_vec += 2;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_err++; $display("FAIL ping got %0d bytes first %h required 1 byte %h", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, exp_q[0]);
    end
    if (pulses != 0) begin n_err++; $display("FAIL ping_bus got %0d cycles required 0", pulses); end
  endtask

  task automatic test_write_read();
    slv_mode = M_BRAM; slv_max_wait = 0;
    do_cmd(OP_WRITE, 32'h0000_0010, 32'hDEAD_BEEF);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL wr_len got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wr_byte%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_vec += 5;
    if (last_adr !== 32'h10)        begin n_err++; $display("FAIL wr_adr got %h required 00000010", last_adr); end
    if (last_dat !== 32'hDEADBEEF)  begin n_err++; $display("FAIL wr_dat got %h required deadbeef", last_dat); end
    if (last_sel !== 4'hF)          begin n_err++; $display("FAIL wr_sel got %h required f", last_sel); end
    if (last_we !== 1'b1)           begin n_err++; $display("FAIL wr_we got %b required 1", last_we); end
    if (cyc_cycles != 1)            begin n_err++; $display("FAIL wr_zero_wait_stb got %0d cycles required 1", cyc_cycles); end
    do_cmd(OP_READ, 32'h0000_0010, 32'h0);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rd_len got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rd_byte%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++;
    if (last_we !== 1'b0) begin n_err++; $display("FAIL rd_we got %b required 0", last_we); end
  endtask

  task automatic test_err_timeout();
    slv_mode = M_ERR;
    do_cmd(OP_WRITE, 32'h5000_0000, 32'h1234_5678);
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_err++; $display("FAIL err_status got %0d bytes first %h required %h", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, exp_q[0]);
    end
    slv_mode = M_SILENT;
    do_cmd(OP_WRITE, 32'h6000_0000, 32'h0);
    n_vec += 2;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_err++; $display("FAIL tmo_status got %0d bytes first %h required %h", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, exp_q[0]);
    end
    if (cyc_cycles != TMO) begin n_err++; $display("FAIL tmo_cycles got %0d required %0d", cyc_cycles, TMO); end
  endtask

  task automatic test_badop_unaligned();
    slv_mode = M_BRAM; slv_max_wait = 2;
    do_cmd(8'h7A, 32'h0, 32'h0);
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_err++; $display("FAIL badop got %0d bytes first %h required %h", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, exp_q[0]);
    end
    do_cmd(OP_PING, 32'h0, 32'h0);
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_err++; $display("FAIL badop_ping got %0d bytes first %h required %h", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, exp_q[0]);
    end
    do_cmd(OP_READ, 32'h0000_0013, 32'h0);
    n_vec += 2;
    if (got_q != exp_q) begin n_err++; $display("FAIL unaligned_rd got %0d bytes %p required %p", got_q.size(), got_q, exp_q); end
    if (last_adr !== 32'h10) begin n_err++; $display("FAIL unaligned_adr got %h required 00000010", last_adr); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    d = $urandom;
    slv_mode = M_ALL; slv_max_wait = 1;
    do_cmd(OP_WRITE, 32'h0000_0030, d);
    n_vec += 2;
    if (got_q != exp_q) begin n_err++; $display("FAIL prio_wr got %p required %p", got_q, exp_q); end
    if (pulses != 1) begin n_err++; $display("FAIL prio_pulses got %0d required 1", pulses); end
    do_cmd(OP_READ, 32'h0000_0030, 32'h0);
    n_vec++;
    if (got_q != exp_q) begin n_err++; $display("FAIL prio_rd got %p required %p", got_q, exp_q); end
  endtask

  task automatic test_retry();
    slv_mode = M_RTY; slv_max_wait = 1; slv_rty_n = 2;
    do_cmd(OP_WRITE, 32'h0000_0040, 32'hA5A5_0001);
    n_vec += 2;
    if (got_q != exp_q) begin n_err++; $display("FAIL rty2_status got %p required %p", got_q, exp_q); end
    if (pulses != exp_pulses) begin n_err++; $display("FAIL rty2_pulses got %0d required %0d", pulses, exp_pulses); end
    slv_rty_n = 5;
    do_cmd(OP_WRITE, 32'h0000_0044, 32'hA5A5_0002);
    n_vec += 2;
    if (got_q != exp_q) begin n_err++; $display("FAIL rty5_status got %p required %p", got_q, exp_q); end
    if (pulses != exp_pulses) begin n_err++; $display("FAIL rty5_pulses got %0d required %0d", pulses, exp_pulses); end
    slv_mode = M_BRAM; slv_rty_n = 0;
    do_cmd(OP_READ, 32'h0000_0040, 32'h0);
    n_vec++;
    if (got_q != exp_q) begin n_err++; $display("FAIL rty_readback got %p required %p", got_q, exp_q); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] fr[9];
    fr = '{OP_WRITE, 8'h70, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    slv_mode = M_SILENT;
    got_q.delete();
    foreach (fr[i]) send_byte(fr[i]);
    repeat (3) @(negedge clk);
    n_vec++;
    if (wb_cyc_o !== 1'b1) begin n_err++; $display("FAIL rstbus_pre cyc got %b required 1", wb_cyc_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec += 3;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
      n_err++; $display("FAIL rstbus_cyc got cyc=%b stb=%b required 0/0", wb_cyc_o, wb_stb_o);
    end
    if (tx_stb !== 1'b0) begin n_err++; $display("FAIL rstbus_txstb got %b required 0", tx_stb); end
    if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL rstbus_state got %0d required IDLE", dbg_state); end
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    n_vec++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL rstbus_tx got %0d bytes required 0", got_q.size()); end
    slv_mode = M_BRAM;
    send_byte(OP_READ); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    do_cmd(OP_PING, 32'h0, 32'h0);
    n_vec++;
    if (got_q != exp_q) begin n_err++; $display("FAIL rstframe_ping got %p required %p", got_q, exp_q); end
  endtask

  task automatic test_random();
    logic [7:0]  op;
    logic [31:0] addr, data;
    int          pick;
    slv_mode = M_BRAM; slv_max_wait = 3;
    for (int k = 0; k < 16; k++) begin
      pick = $urandom_range(0, 9);
      addr = 32'h100 + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      data = $urandom;
      if (pick < 4)       op = OP_WRITE;
      else if (pick < 8)  op = OP_READ;
      else if (pick == 8) op = OP_PING;
      else                op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(4, 255));
      do_cmd(op, addr, data);
      n_vec++;
      if (got_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL rand%0d_len op=%h got %0d required %0d", k, op, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rand%0d_byte%0d op=%h got %h required %h", k, i, op, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ping();
    test_write_read();
    test_err_timeout();
    test_badop_unaligned();
    test_priority();
    test_retry();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
